// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: fixed-priority CPU port, starvation-protected EXT port.
// Define ARB_STATS_EN to add the stall_cycles / ext_grants counters.
module data_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_valid,
    output logic [31:0] ext_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
`ifdef ARB_STATS_EN
    input  logic [31:0] mem_rdata,
    output logic [31:0] stall_cycles,
    output logic [15:0] ext_grants
`else
    input  logic [31:0] mem_rdata
`endif
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t      state;
    logic        owner_ext;
    logic [2:0]  lat_cnt;
    logic [7:0]  starve_cnt;
    logic [31:0] addr_q;
    logic [31:0] cpu_hold;
    logic [31:0] ext_hold;

    logic is_idle;
    logic force_ext;
    logic cpu_iss;
    logic ext_iss;
    logic dlv;
    logic cpu_dlv;
    logic ext_dlv;

    assign is_idle   = (state == IDLE);
    assign force_ext = ext_req && (starve_cnt == 8'(STARVE_MAX));
    assign cpu_iss   = is_idle && cpu_req && !force_ext;
    assign ext_iss   = is_idle && ext_req && !cpu_iss;
    assign dlv       = (state == RD_WAIT) && (lat_cnt == 3'(MEM_LAT));
    assign cpu_dlv   = dlv && !owner_ext;
    assign ext_dlv   = dlv && owner_ext;

    // Everything is forced low while reset is held.
    always_comb begin
        cpu_rdata = '0;
        ext_rdata = '0;
        cpu_stall = 1'b0;
        ext_gnt   = 1'b0;
        ext_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            cpu_rdata = cpu_dlv ? mem_rdata : cpu_hold;
            ext_rdata = ext_dlv ? mem_rdata : ext_hold;
            cpu_stall = cpu_req && !(cpu_iss && cpu_we) && !cpu_dlv;
            ext_gnt   = ext_iss;
            ext_valid = ext_dlv;
            if (cpu_iss) begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end else if (ext_iss) begin
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end else if (state == RD_WAIT) begin
                mem_addr  = addr_q;
            end
        end
    end

    // EXT may change its address after the grant, so the read address is latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_ext  <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            addr_q     <= '0;
            cpu_hold   <= '0;
            ext_hold   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_iss && !cpu_we) begin
                        state     <= RD_WAIT;
                        owner_ext <= 1'b0;
                        lat_cnt   <= 3'd1;
                        addr_q    <= cpu_addr;
                    end else if (ext_iss && !ext_we) begin
                        state     <= RD_WAIT;
                        owner_ext <= 1'b1;
                        lat_cnt   <= 3'd1;
                        addr_q    <= ext_addr;
                    end
                end
                RD_WAIT: begin
                    if (dlv) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                        if (owner_ext) ext_hold <= mem_rdata;
                        else           cpu_hold <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!ext_req || ext_iss)
                starve_cnt <= '0;
            else if (starve_cnt != 8'(STARVE_MAX))
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            ext_grants   <= '0;
        end else begin
            if (cpu_stall) stall_cycles <= stall_cycles + 32'd1;
            if (ext_gnt)   ext_grants   <= ext_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one instance with MEM_LAT=1,
// one with MEM_LAT=3, sharing stimulus, each with its own memory model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

    logic [31:0] d1_cpu_rdata, d1_ext_rdata, d1_mem_addr, d1_mem_wdata;
    logic [31:0] d1_mem_rdata;
    logic        d1_cpu_stall, d1_ext_gnt, d1_ext_valid, d1_mem_we;
    logic [31:0] d3_cpu_rdata, d3_ext_rdata, d3_mem_addr, d3_mem_wdata;
    logic [31:0] d3_mem_rdata;
    logic        d3_cpu_stall, d3_ext_gnt, d3_ext_valid, d3_mem_we;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p3_0, p3_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_d1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(d1_cpu_rdata), .cpu_stall(d1_cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(d1_ext_gnt), .ext_valid(d1_ext_valid),
        .ext_rdata(d1_ext_rdata),
        .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
        .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
    );

    data_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_d3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(d3_cpu_rdata), .cpu_stall(d3_cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(d3_ext_gnt), .ext_valid(d3_ext_valid),
        .ext_rdata(d3_ext_rdata),
        .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
        .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4)  return 32'hDEADBEEF;
        if (i == 16) return 32'h0BADF00D;
        if (i == 32) return 32'hCAFEF00D;
        return 32'hA5A50000 | i;
    endfunction

    // Synchronous memories: 1-cycle and 3-cycle read pipelines.
    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
        else if (d1_mem_we)
            mem1[d1_mem_addr[9:2]] <= d1_mem_wdata;
        d1_mem_rdata <= mem1[d1_mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
        else if (d3_mem_we)
            mem3[d3_mem_addr[9:2]] <= d3_mem_wdata;
        p3_0         <= mem3[d3_mem_addr[9:2]];
        p3_1         <= p3_0;
        d3_mem_rdata <= p3_1;
    end

    wire [133:0] z1 = {d1_cpu_rdata, d1_ext_rdata, d1_mem_addr, d1_mem_wdata,
                       d1_cpu_stall, d1_ext_gnt, d1_ext_valid, d1_mem_we,
                       2'b00};
    wire [133:0] z3 = {d3_cpu_rdata, d3_ext_rdata, d3_mem_addr, d3_mem_wdata,
                       d3_cpu_stall, d3_ext_gnt, d3_ext_valid, d3_mem_we,
                       2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (z1 !== '0) begin errors++; $display("FAIL rst_outs_d1 got=%h want=0", z1); end
            checks++;
            if (z3 !== '0) begin errors++; $display("FAIL rst_outs_d3 got=%h want=0", z3); end
            tick();
        end
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        checks++;
        if (d1_mem_addr !== 32'h10) begin errors++; $display("FAIL first_issue_addr got=%h want=10", d1_mem_addr); end
        checks++;
        if (d1_ext_gnt !== 1'b0) begin errors++; $display("FAIL first_issue_gnt got=%b want=0", d1_ext_gnt); end
        checks++;
        if (d1_cpu_stall !== 1'b1) begin errors++; $display("FAIL first_issue_stall got=%b want=1", d1_cpu_stall); end
        tick();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (d1_cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_t got=%b want=1", d1_cpu_stall); end
        checks++;
        if (d1_mem_addr !== 32'h10 || d1_mem_we !== 1'b0) begin
            errors++; $display("FAIL rd_bus_t got=%h/%b want=10/0", d1_mem_addr, d1_mem_we);
        end
        tick();
        @(negedge clk);
        checks++;
        if (d1_cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall_t1 got=%b want=0", d1_cpu_stall); end
        checks++;
        if (d1_cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_t1 got=%h want=deadbeef", d1_cpu_rdata); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d1_cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got=%h want=deadbeef", d1_cpu_rdata); end
        checks++;
        if (d1_mem_addr !== '0 || d1_mem_we !== 1'b0 || d1_cpu_stall !== 1'b0) begin
            errors++; $display("FAIL idle_bus got=%h/%b/%b want=0/0/0", d1_mem_addr, d1_mem_we, d1_cpu_stall);
        end
        tick();
    endtask

    task automatic test_cpu_write();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (d1_mem_we !== 1'b1 || d1_mem_addr !== 32'h20 || d1_mem_wdata !== 32'h55) begin
            errors++; $display("FAIL wr_bus got=%b/%h/%h want=1/20/55", d1_mem_we, d1_mem_addr, d1_mem_wdata);
        end
        checks++;
        if (d1_cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall got=%b want=0", d1_cpu_stall); end
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if (d1_cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_rd_stall got=%b want=1", d1_cpu_stall); end
        tick();
        @(negedge clk);
        checks++;
        if (d1_cpu_stall !== 1'b0 || d1_cpu_rdata !== 32'h55) begin
            errors++; $display("FAIL wr_readback got=%b/%h want=0/55", d1_cpu_stall, d1_cpu_rdata);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_starvation();
        logic exp_g;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'h77;
        for (int c = 1; c <= 10; c++) begin
            cpu_wdata = c;
            exp_g = (c % 5 == 0);
            @(negedge clk);
            checks++;
            if (d1_ext_gnt !== exp_g) begin errors++; $display("FAIL starve_gnt c%0d got=%b want=%b", c, d1_ext_gnt, exp_g); end
            checks++;
            if (d1_cpu_stall !== exp_g) begin errors++; $display("FAIL starve_stall c%0d got=%b want=%b", c, d1_cpu_stall, exp_g); end
            checks++;
            if (d1_mem_addr !== (exp_g ? 32'h30 : 32'h24) || d1_mem_we !== 1'b1) begin
                errors++; $display("FAIL starve_addr c%0d got=%h/%b want=%h/1", c, d1_mem_addr, d1_mem_we, exp_g ? 32'h30 : 32'h24);
            end
            if (exp_g) begin
                checks++;
                if (d1_mem_wdata !== 32'h77) begin errors++; $display("FAIL starve_wdata got=%h want=77", d1_mem_wdata); end
            end
            tick();
        end
    endtask

    task automatic test_ext_drop();
        logic [8:0] pat;
        pat = 9'b111110111;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h28; cpu_wdata = 32'h1;
        ext_we = 1'b1; ext_addr = 32'h34; ext_wdata = 32'h2;
        for (int i = 0; i < 9; i++) begin
            ext_req = pat[i];
            @(negedge clk);
            checks++;
            if (d1_ext_gnt !== (i == 8)) begin errors++; $display("FAIL drop_gnt i%0d got=%b want=%b", i, d1_ext_gnt, i == 8); end
            tick();
        end
        ext_req = 1'b0;
    endtask

    task automatic test_ext_read();
        do_reset();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (d3_ext_gnt !== 1'b1 || d3_mem_addr !== 32'h40 || d3_mem_we !== 1'b0) begin
            errors++; $display("FAIL ext_issue got=%b/%h/%b want=1/40/0", d3_ext_gnt, d3_mem_addr, d3_mem_we);
        end
        tick();
        ext_req = 1'b0; ext_addr = 32'h44;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            checks++;
            if (d3_cpu_stall !== (t < 7)) begin errors++; $display("FAIL ext_cpu_stall t%0d got=%b want=%b", t, d3_cpu_stall, t < 7); end
            checks++;
            if (d3_ext_valid !== (t == 3)) begin errors++; $display("FAIL ext_valid t%0d got=%b want=%b", t, d3_ext_valid, t == 3); end
            if (t < 3) begin
                checks++;
                if (d3_mem_addr !== 32'h40) begin errors++; $display("FAIL ext_hold_addr t%0d got=%h want=40", t, d3_mem_addr); end
            end
            if (t >= 3) begin
                checks++;
                if (d3_ext_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL ext_rdata t%0d got=%h want=0badf00d", t, d3_ext_rdata); end
            end
            if (t == 4) begin
                checks++;
                if (d3_mem_addr !== 32'h80) begin errors++; $display("FAIL cpu_after_ext_addr got=%h want=80", d3_mem_addr); end
            end
            if (t == 7) begin
                checks++;
                if (d3_cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL cpu_after_ext_data got=%h want=cafef00d", d3_cpu_rdata); end
            end
            tick();
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (d3_ext_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b want=1", d3_ext_gnt); end
        tick();
        rst = 1'b1; ext_req = 1'b0;
        @(negedge clk);
        checks++;
        if (z3 !== '0) begin errors++; $display("FAIL mid_rst_outs got=%h want=0", z3); end
        tick();
        rst = 1'b0;
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk);
            checks++;
            if (d3_ext_valid !== 1'b0 || d3_ext_rdata !== '0) begin
                errors++; $display("FAIL mid_abandon t%0d got=%b/%h want=0/0", t, d3_ext_valid, d3_ext_rdata);
            end
            checks++;
            if (d3_mem_addr !== '0) begin errors++; $display("FAIL mid_idle_addr t%0d got=%h want=0", t, d3_mem_addr); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; ext_wdata = '0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_starvation();
        test_ext_drop();
        test_ext_read();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
